spmv_row_mac: RTL and testbench
===============================

Name: spmv_row_mac

Overview:
- Downstream consumer of the HHT sparse-matrix fetch controller.
- Receives a stream of (matrix value, vector value) operand pairs tagged with row boundaries, and computes one dot product per CSR row.
- Buffers finished row sums in a small result FIFO.
- Hands each result to the writeback/CPU side over a valid/ready interface.

Parameters:
- DW, 32, operand width of matrix and vector values.
- AW, 72, accumulator and result width; must be at least 2*DW.
- RW, 16, row-index width.
- OUT_DEPTH, 4, result FIFO depth; power of two, at least 2.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse that begins a matrix pass; sampled only in IDLE.
- nrows  input  RW  number of rows in the pass; sampled on start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_mval  input  DW  matrix nonzero value.
- in_vval  input  DW  vector element paired with it.
- in_last  input  1  beat is the final nonzero of the current row.
- in_empty  input  1  row has no nonzeros; in_mval/in_vval ignored; implies last.
- out_valid  output  1  result FIFO head valid.
- out_ready  input  1  consumer takes the head.
- out_row  output  RW  row index of the head result.
- out_sum  output  AW  row dot product.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_row=0, out_sum=0, busy=0, done=0. FSM goes to IDLE; accumulator, row counter and FIFO pointers are cleared.
- Reset mid-pass drops all in-flight beats and buffered results. No done pulse is issued.
- FSM states and transitions:
  - IDLE -> RUN on start. If nrows=0, IDLE -> FIN directly.
  - RUN -> DRAIN when the row counter reaches nrows.
  - DRAIN -> FIN when the pipeline is empty and the FIFO is empty.
  - FIN -> IDLE unconditionally; done=1 during FIN.
- start outside IDLE is ignored.
- Pipeline stage 1 (registered): product = in_mval*in_vval, unsigned, 2*DW bits, zero-extended to AW.
- Pipeline stage 2: acc <= acc + product, modulo 2^AW.
- On a last or empty beat, stage 2 pushes {row_cnt, acc+product} into the FIFO (or {row_cnt, 0} for empty), clears acc, and increments row_cnt.
- Latency: a last beat accepted on edge t is visible as the FIFO head at out_valid on edge t+2 when the FIFO was empty.
- Credit rule:
  - in_ready = (state==RUN) && (fifo_count + rows_in_flight < OUT_DEPTH).
  - rows_in_flight counts last/empty beats accepted but not yet pushed.
  - The FIFO never overflows, and no beat is ever dropped.
- Beats without in_last never consume a credit, but accepting them still requires in_ready.
- Simultaneous push and pop on a full FIFO is allowed; the count is unchanged.
- Pop on empty is impossible, because out_valid=0.
- out_row/out_sum hold stable while out_valid && !out_ready.
- in_ready=0 once row_cnt==nrows. Extra beats stay unaccepted.
- in_last and in_empty both high on one beat is treated as empty.
- row_cnt wraps modulo 2^RW; nrows bounds the pass, so this is benign.

Optional Feature:
- Macro: SPMV_ROW_MAC_SAT_EN.
- Defined: the stage-2 add saturates at 2^AW-1. A sticky sat_flag output (1 bit, cleared on start and on Rst) is added and set whenever any row clamps.
- Undefined: the add wraps modulo 2^AW, and the sat_flag port does not exist.

Decomposition:
- Package spmv_pkg:
  - DW/AW/RW defaults.
  - fsm_e enum {IDLE, RUN, DRAIN, FIN}.
  - row_res_t struct {row, sum}.
- Sub-module spmv_res_fifo:
  - Parameterised on row_res_t and OUT_DEPTH.
  - Ports: push/pop/full/empty/count.
  - Holds the credit-count logic.

Test Plan:
- Single row, nrows=1, beats (45,8),(66,98 last) -> out_row=0, out_sum=6828, done one cycle after pop.
- nrows=3 with row1 empty -> three results in order, sums {360, 0, 6468}, rows {0,1,2}.
- out_ready held 0 while 6 single-beat rows are streamed, OUT_DEPTH=4:
  - in_ready drops after 4 credits are used.
  - After out_ready is released, all 6 results arrive in order with none lost.
- Rst asserted mid-row after 5 beats:
  - All outputs return to reset values immediately.
  - A fresh start with nrows=1, beat (7,7 last) yields 49.
- With SPMV_ROW_MAC_SAT_EN, DW=32, AW=64: three beats of (2^32-1, 2^32-1) -> out_sum=2^64-1, sat_flag=1. Without the macro the sum wraps.
- start pulse during RUN and nrows=0 start -> the RUN pulse is ignored; nrows=0 gives done on the 2nd cycle with no outputs.

Source files
------------

// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared defaults and types for the SpMV row MAC
package spmv_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 72;
  localparam int RW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } fsm_e;

  typedef struct packed {
    logic [RW_DEF-1:0] row;
    logic [AW_DEF-1:0] sum;
  } row_res_t;

endpackage

// File: rtl/spmv_res_fifo.sv
// rtl/spmv_res_fifo.sv - row-result FIFO with credit accounting for rows still in the pipeline
module spmv_res_fifo
  import spmv_pkg::*;
#(
  parameter type T     = row_res_t,
  parameter int  DEPTH = 4,
  parameter int  CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic [CW-1:0] rsv,
  output T              head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          credit_ok
);

  localparam int PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   committed;

  // Pointer and occupancy update; a push and pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage; slots are only read once the head pointer reaches a written entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // A new row may only start when its result is guaranteed a slot.
  assign committed = {1'b0, count_q} + {1'b0, rsv};
  assign credit_ok = committed < (CW+1)'(DEPTH);

  assign head  = mem_q[rd_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/spmv_row_mac.sv
// rtl/spmv_row_mac.sv - per-row dot-product MAC with result FIFO; SPMV_ROW_MAC_SAT_EN adds saturating accumulate and sat_flag
module spmv_row_mac
  import spmv_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int RW        = RW_DEF,
  parameter int OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] nrows,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_mval,
  input  logic [DW-1:0] in_vval,
  input  logic          in_last,
  input  logic          in_empty,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [AW-1:0] out_sum,
  output logic          busy,
`ifdef SPMV_ROW_MAC_SAT_EN
  output logic          sat_flag,
`endif
  output logic          done
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [AW-1:0] sum;
  } res_t;

  fsm_e            state_q, state_d;
  logic [RW-1:0]   nrows_q, nrows_d;
  logic [RW-1:0]   rows_acc_q, rows_acc_d;   // row ends accepted at the input
  logic [RW-1:0]   row_cnt_q, row_cnt_d;     // row ends retired into the FIFO
  logic            s1_valid_q, s1_valid_d;
  logic            s1_last_q, s1_last_d;
  logic            s1_empty_q, s1_empty_d;
  logic [2*DW-1:0] s1_prod_q, s1_prod_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            push_q, push_d;
  res_t            push_res_q, push_res_d;
  logic [AW-1:0]   acc_next;
  logic            accept, pop, pipe_idle;
  logic            fifo_full, fifo_empty, credit_ok;
  logic [CW-1:0]   fifo_count, inflight;
  res_t            head;
`ifdef SPMV_ROW_MAC_SAT_EN
  logic            sat_q, sat_d;
  logic [AW:0]     sum_wide;
  logic            clamp;
`endif

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign inflight  = CW'(s1_valid_q && s1_last_q) + CW'(push_q);
  assign pipe_idle = !s1_valid_q && !push_q;
  assign in_ready  = (state_q == RUN) && (rows_acc_q != nrows_q) && credit_ok && !fifo_full;

  // Stage-2 adder: clamps at all-ones when saturation is built in, otherwise wraps.
  always_comb begin
`ifdef SPMV_ROW_MAC_SAT_EN
    sum_wide = {1'b0, acc_q} + {1'b0, AW'(s1_prod_q)};
    clamp    = sum_wide[AW];
    acc_next = clamp ? '1 : sum_wide[AW-1:0];
`else
    acc_next = acc_q + AW'(s1_prod_q);
`endif
  end

  // Multiply stage, accumulate/push stage and pass-control FSM.
  always_comb begin
    state_d    = state_q;
    nrows_d    = nrows_q;
    rows_acc_d = rows_acc_q;
    row_cnt_d  = row_cnt_q;
    acc_d      = acc_q;
    push_d     = 1'b0;
    push_res_d = push_res_q;
`ifdef SPMV_ROW_MAC_SAT_EN
    sat_d      = sat_q;
`endif
    s1_valid_d = accept;
    s1_last_d  = in_last || in_empty;
    s1_empty_d = in_empty;
    s1_prod_d  = {{DW{1'b0}}, in_mval} * {{DW{1'b0}}, in_vval};

    if (accept && (in_last || in_empty)) rows_acc_d = rows_acc_q + RW'(1);

    if (s1_valid_q) begin
      if (s1_empty_q) begin
        push_d         = 1'b1;
        push_res_d.row = row_cnt_q;
        push_res_d.sum = '0;
        acc_d          = '0;
        row_cnt_d      = row_cnt_q + RW'(1);
      end else begin
`ifdef SPMV_ROW_MAC_SAT_EN
        if (clamp) sat_d = 1'b1;
`endif
        if (s1_last_q) begin
          push_d         = 1'b1;
          push_res_d.row = row_cnt_q;
          push_res_d.sum = acc_next;
          acc_d          = '0;
          row_cnt_d      = row_cnt_q + RW'(1);
        end else begin
          acc_d = acc_next;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          nrows_d    = nrows;
          rows_acc_d = '0;
          row_cnt_d  = '0;
          acc_d      = '0;
`ifdef SPMV_ROW_MAC_SAT_EN
          sat_d      = 1'b0;
`endif
          state_d    = (nrows == '0) ? FIN : RUN;
        end
      end
      RUN:     if (rows_acc_q == nrows_q) state_d = DRAIN;
      DRAIN:   if (pipe_idle && (fifo_empty || (fifo_count == CW'(1) && pop))) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nrows_q    <= '0;
      rows_acc_q <= '0;
      row_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_empty_q <= 1'b0;
      s1_prod_q  <= '0;
      acc_q      <= '0;
      push_q     <= 1'b0;
      push_res_q <= '0;
`ifdef SPMV_ROW_MAC_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      nrows_q    <= nrows_d;
      rows_acc_q <= rows_acc_d;
      row_cnt_q  <= row_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_empty_q <= s1_empty_d;
      s1_prod_q  <= s1_prod_d;
      acc_q      <= acc_d;
      push_q     <= push_d;
      push_res_q <= push_res_d;
`ifdef SPMV_ROW_MAC_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  spmv_res_fifo #(
    .T     (res_t),
    .DEPTH (OUT_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_res_q),
    .pop       (pop),
    .rsv       (inflight),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .credit_ok (credit_ok)
  );

  assign out_valid = !fifo_empty;
  assign out_row   = out_valid ? head.row : '0;
  assign out_sum   = out_valid ? head.sum : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
`ifdef SPMV_ROW_MAC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_spmv_row_mac.sv
// tb/tb_spmv_row_mac.sv - self-checking bench for spmv_row_mac
module tb_spmv_row_mac;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int RW = 16;
  localparam int OUT_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] nrows = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_mval = '0;
  logic [DW-1:0] in_vval = '0;
  logic          in_last = 1'b0;
  logic          in_empty = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_row;
  logic [AW-1:0] out_sum;
  logic          busy;
  logic          done;
`ifdef SPMV_ROW_MAC_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  spmv_row_mac #(.DW(DW), .AW(AW), .RW(RW), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mval   (in_mval),
    .in_vval   (in_vval),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_sum   (out_sum),
    .busy      (busy),
`ifdef SPMV_ROW_MAC_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .done      (done)
  );

  typedef struct { logic [DW-1:0] m; logic [DW-1:0] v; logic last; logic empty; } beat_t;
  typedef struct { logic [RW-1:0] row; logic [AW-1:0] sum; } res_t;
  typedef struct { logic [DW-1:0] m0, v0, m1, v1; logic [AW-1:0] sum; } vec_t;

  beat_t        beats[$];
  res_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           row_idx = 0;
  logic [127:0] racc = '0;
  bit           sat_exp = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [AW-1:0] fold(input logic [127:0] x);
`ifdef SPMV_ROW_MAC_SAT_EN
    if (x[127:AW] != '0) return '1;
`endif
    return x[AW-1:0];
  endfunction

  // Reference model: exact-width row sums, reduced to the result width only at row end.
  task automatic add_beat(input logic [DW-1:0] m, input logic [DW-1:0] v, input bit last, input bit empty);
    beat_t b;
    res_t  r;
    b.m = m; b.v = v; b.last = last; b.empty = empty;
    beats.push_back(b);
    if (!empty) racc = racc + 128'(m) * 128'(v);
    if (empty || last) begin
      r.row = RW'(row_idx);
      r.sum = empty ? '0 : fold(racc);
      if (!empty && racc[127:AW] != '0) sat_exp = 1'b1;
      exp_q.push_back(r);
      row_idx++;
      racc = '0;
    end
  endtask

  task automatic start_pass(input int n);
    start = 1'b1; nrows = RW'(n);
    row_idx = 0; racc = '0; sat_exp = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beats(input bit gaps);
    int cyc = 0;
    while (beats.size() > 0 && cyc < 2000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_mval  = beats[0].m;
        in_vval  = beats[0].v;
        in_last  = beats[0].last;
        in_empty = beats[0].empty;
        if (in_ready) void'(beats.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (beats.size() > 0) begin
      check("drive_timeout", 128'(beats.size()), 128'(0));
      beats.delete();
    end
  endtask

  task automatic collect(input int n, input bit rnd);
    int            got = 0;
    int            cyc = 0;
    bit            hold = 1'b0;
    logic [RW-1:0] hrow = '0;
    logic [AW-1:0] hsum = '0;
    res_t          e;
    while (got < n && cyc < 2000) begin
      if (hold) check("out_hold", 128'({out_valid, out_row, out_sum}), 128'({1'b1, hrow, hsum}));
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      hold = out_valid && !out_ready;
      hrow = out_row;
      hsum = out_sum;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got row %0d sum 0x%0h, expected none", out_row, out_sum);
        end else begin
          n_checks--;
          e = exp_q.pop_front();
          check("out_row", 128'(out_row), 128'(e.row));
          check("out_sum", 128'(out_sum), 128'(e.sum));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (got < n) check("collect_timeout", 128'(got), 128'(n));
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_done_lat"}, 128'(cyc), 128'(0));
    check({name, "_left"}, 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
    check({name, "_after_done"}, 128'({done, busy, out_valid}), 128'(3'b000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{32'd45, 32'd8, 32'd66, 32'd98, 64'd6828};
    tbl[1] = '{32'd0, 32'd5, 32'd7, 32'd3, 64'd21};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 64'h1_0000_0000};
    tbl[3] = '{32'd1000, 32'd1000, 32'd0, 32'd9, 64'd1000000};
    tbl[4] = '{32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000, 64'h2_0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_out_sum", 128'(out_sum), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: single two-beat rows, done one cycle after the pop
    foreach (tbl[i]) begin
      beat_t b0, b1;
      res_t  r;
      start_pass(1);
      check("tbl_busy", 128'(busy), 128'(1));
      b0.m = tbl[i].m0; b0.v = tbl[i].v0; b0.last = 1'b0; b0.empty = 1'b0;
      b1.m = tbl[i].m1; b1.v = tbl[i].v1; b1.last = 1'b1; b1.empty = 1'b0;
      beats.push_back(b0);
      beats.push_back(b1);
      r.row = '0; r.sum = tbl[i].sum;
      exp_q.push_back(r);
      fork drive_beats(1'b0); collect(1, 1'b0); join
      wait_done("tbl");
    end

    // Two-edge latency from last-beat acceptance to FIFO head
    start_pass(1);
    add_beat(32'd11, 32'd11, 1'b1, 1'b0);
    void'(beats.pop_front());
    in_valid = 1'b1; in_mval = 32'd11; in_vval = 32'd11; in_last = 1'b1; in_empty = 1'b0;
    check("lat_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_t0", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_t1", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check("lat_t2", 128'({out_valid, out_sum}), 128'({1'b1, 64'd121}));
    collect(1, 1'b0);
    wait_done("lat");

    // Three rows with an empty middle row
    start_pass(3);
    add_beat(32'd10, 32'd12, 1'b0, 1'b0);
    add_beat(32'd20, 32'd12, 1'b1, 1'b0);
    add_beat(32'd0, 32'd0, 1'b1, 1'b1);
    add_beat(32'd66, 32'd98, 1'b1, 1'b0);
    check("three_row_model", 128'({exp_q[0].sum, exp_q[2].sum}), 128'({64'd360, 64'd6468}));
    fork drive_beats(1'b0); collect(3, 1'b0); join
    wait_done("three_row");

    // Backpressure: 6 single-beat rows against a 4-deep result FIFO
    start_pass(6);
    for (int i = 0; i < 6; i++) add_beat(32'(i + 3), 32'(10 * i + 1), 1'b1, 1'b0);
    begin : bp
      int acc_n;
      acc_n = 0;
      for (int c = 0; c < 20; c++) begin
        in_valid = 1'b1;
        in_mval  = beats[0].m;
        in_vval  = beats[0].v;
        in_last  = beats[0].last;
        in_empty = beats[0].empty;
        if (in_ready) begin
          void'(beats.pop_front());
          acc_n++;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", 128'(acc_n), 128'(4));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(1));
    end
    fork drive_beats(1'b0); collect(6, 1'b0); join
    wait_done("bp");

    // Reset in the middle of a row
    start_pass(2);
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      b.m = 32'(i + 1); b.v = 32'd2; b.last = 1'b0; b.empty = 1'b0;
      beats.push_back(b);
    end
    drive_beats(1'b0);
    check("mid_busy", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs", 128'({in_ready, out_valid, out_row, out_sum, busy, done}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_no_done", 128'(done), 128'(0));
    start_pass(1);
    add_beat(32'd7, 32'd7, 1'b1, 1'b0);
    fork drive_beats(1'b0); collect(1, 1'b0); join
    wait_done("post_rst");

    // Saturation or wrap on three maximal products
    start_pass(1);
    for (int i = 0; i < 3; i++) add_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, i == 2, 1'b0);
    fork drive_beats(1'b0); collect(1, 1'b0); join
`ifdef SPMV_ROW_MAC_SAT_EN
    check("sat_flag_set", 128'(sat_flag), 128'(1));
`endif
    wait_done("sat");

    // start while running is ignored; nrows=0 finishes immediately
    start_pass(2);
`ifdef SPMV_ROW_MAC_SAT_EN
    check("sat_flag_cleared", 128'(sat_flag), 128'(0));
`endif
    start = 1'b1; nrows = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_start_busy", 128'(busy), 128'(1));
    add_beat(32'd3, 32'd4, 1'b0, 1'b0);
    add_beat(32'd5, 32'd6, 1'b1, 1'b0);
    add_beat(32'd9, 32'd9, 1'b1, 1'b0);
    fork drive_beats(1'b0); collect(2, 1'b0); join
    wait_done("run_start");
    start_pass(0);
    check("zero_rows_out_valid", 128'(out_valid), 128'(0));
    wait_done("zero_rows");

    // Randomized passes against the reference model
    for (int p = 0; p < 10; p++) begin
      int n;
      n = $urandom_range(1, 6);
      start_pass(n);
      for (int r = 0; r < n; r++) begin
        int len;
        len = $urandom_range(0, 4);
        if (len == 0) begin
          add_beat(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end else begin
          for (int b = 0; b < len; b++) begin
            if (p % 2 == 0) add_beat(32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000)), b == len - 1, 1'b0);
            else add_beat(32'($urandom), 32'($urandom), b == len - 1, 1'b0);
          end
        end
      end
      fork drive_beats(1'b1); collect(n, 1'b1); join
`ifdef SPMV_ROW_MAC_SAT_EN
      check("rand_sat_flag", 128'(sat_flag), 128'(sat_exp));
`endif
      wait_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
